// File: rtl/ioblock_pkg.sv
// rtl/ioblock_pkg.sv - shared TSMUX encodings and serializer state for the IO block output path
package ioblock_pkg;

    localparam logic [1:0] TS_OFF  = 2'b00;
    localparam logic [1:0] TS_FAB  = 2'b01;
    localparam logic [1:0] TS_AUTO = 2'b10;
    localparam logic [1:0] TS_ON   = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/ioblock_obuf.sv
// rtl/ioblock_obuf.sv - pad driver: output enable select, data mux and PIN tristate
module ioblock_obuf
    import ioblock_pkg::*;
(
    input  logic [1:0] tsmux_i,
    input  logic       ts_q_i,
    input  state_e     state_i,
    input  logic       osel_i,
    input  logic       ser_i,
    input  logic       out_i,
    output logic       en_o,
    inout  wire        pad_io
);

    always_comb begin
        en_o = 1'b0;
        case (tsmux_i)
            TS_OFF:  en_o = 1'b0;
            TS_FAB:  en_o = ts_q_i;
            TS_AUTO: en_o = (state_i == SHIFT);
            default: en_o = 1'b1;
        endcase
    end

    assign pad_io = en_o ? (osel_i ? ser_i : out_i) : 1'bz;

endmodule

// File: rtl/ioblock_oser.sv
// rtl/ioblock_oser.sv - parallel-to-serial pad driver with one-word holding buffer, LSB first
module ioblock_oser
    import ioblock_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic             IOCLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DVALID,
    output logic             DREADY,
    input  logic [1:0]       TSMUX,
    input  logic             TS,
    input  logic             OSEL,
    input  logic             OUT,
    output logic             DONE,
    output logic             IN,
    inout  wire              PIN
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] hold_q;
    logic             hold_v_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    state_e           state_q;
    logic             ts_q;
    logic             ser_bit;
    logic             last_bit;
    logic             pad_en;

    assign last_bit = (state_q == SHIFT) && (cnt_q == CNT_LAST);

    // Accept needs an empty buffer and drain needs a full one, so the two
    // hold_v_q assignments below never fire on the same edge.
    always_ff @(posedge IOCLK) begin
        if (!RSTN) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            sr_q     <= '0;
            cnt_q    <= '0;
            state_q  <= IDLE;
            ts_q     <= 1'b0;
        end else begin
            ts_q <= TS;
            if (DVALID && !hold_v_q) begin
                hold_q   <= DIN;
                hold_v_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (hold_v_q) begin
                        sr_q     <= hold_q;
                        hold_v_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= SHIFT;
                    end
                end
                default: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (hold_v_q) begin
                            sr_q     <= hold_q;
                            hold_v_q <= 1'b0;
                        end else begin
                            sr_q    <= sr_q >> 1;
                            state_q <= IDLE;
                        end
                    end else begin
                        sr_q  <= sr_q >> 1;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase
        end
    end

    assign ser_bit = (state_q == SHIFT) ? sr_q[0] : IDLE_LVL;
    assign DREADY  = !hold_v_q;
    assign DONE    = last_bit;
    assign IN      = PIN;

    ioblock_obuf u_obuf (
        .tsmux_i (TSMUX),
        .ts_q_i  (ts_q),
        .state_i (state_q),
        .osel_i  (OSEL),
        .ser_i   (ser_bit),
        .out_i   (OUT),
        .en_o    (pad_en),
        .pad_io  (PIN)
    );

endmodule

// File: tb/tb_ioblock_oser.sv
// tb/tb_ioblock_oser.sv - directed self-checking bench for ioblock_oser
module tb_ioblock_oser;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] din;
    logic       dvalid;
    logic       dready;
    logic [1:0] tsmux;
    logic       ts;
    logic       osel;
    logic       out_b;
    logic       done;
    logic       in_b;
    wire        pin;

    int checks = 0;
    int errors = 0;

    // An undriven pad reads 0; Z is confirmed through the pad enable as well.
    pulldown (pin);

    ioblock_oser #(.WIDTH(8), .IDLE_LVL(1'b1)) dut (
        .IOCLK  (clk),
        .RSTN   (rstn),
        .DIN    (din),
        .DVALID (dvalid),
        .DREADY (dready),
        .TSMUX  (tsmux),
        .TS     (ts),
        .OSEL   (osel),
        .OUT    (out_b),
        .DONE   (done),
        .IN     (in_b),
        .PIN    (pin)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; din = 8'h00; dvalid = 1'b0; tsmux = 2'b11;
        ts = 1'b0; osel = 1'b1; out_b = 1'b0;
        tick; tick;
        checks++;
        if (pin !== 1'b1 || in_b !== 1'b1) begin
            errors++; $display("FAIL reset_pin_on: pin=%b in=%b expected 1", pin, in_b);
        end
        checks++;
        if (dready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: dready=%b done=%b expected 1/0", dready, done);
        end
        tsmux = 2'b00;
        #1;
        checks++;
        if (dut.u_obuf.en_o !== 1'b0 || pin !== 1'b0) begin
            errors++; $display("FAIL reset_pin_z: en=%b pin=%b expected 0/Z", dut.u_obuf.en_o, pin);
        end
        rstn = 1'b1; tsmux = 2'b11;
        tick;
    endtask

    task automatic test_single;
        logic [7:0] w;
        w = 8'hA5;
        din = w; dvalid = 1'b1;
        tick;
        dvalid = 1'b0;
        checks++;
        if (dready !== 1'b0 || pin !== 1'b1) begin
            errors++; $display("FAIL single_accept: dready=%b pin=%b expected 0/1", dready, pin);
        end
        tick;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pin !== w[i] || in_b !== w[i] || done !== (i == 7)) begin
                errors++;
                $display("FAIL single_bit%0d: pin=%b in=%b done=%b expected %b/%b/%b",
                         i, pin, in_b, done, w[i], w[i], (i == 7));
            end
            tick;
        end
        checks++;
        if (pin !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL single_idle: pin=%b done=%b expected 1/0", pin, done);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_pin, exp_rdy, exp_done;
        din = 8'hFF; dvalid = 1'b1;
        tick;
        din = 8'h00;
        tick;
        for (int i = 0; i < 16; i++) begin
            exp_pin  = (i < 8);
            exp_rdy  = (i == 0) || (i >= 8);
            exp_done = (i == 7) || (i == 15);
            checks++;
            if (pin !== exp_pin || dready !== exp_rdy || done !== exp_done) begin
                errors++;
                $display("FAIL b2b_bit%0d: pin=%b dready=%b done=%b expected %b/%b/%b",
                         i, pin, dready, done, exp_pin, exp_rdy, exp_done);
            end
            if (i == 1) dvalid = 1'b0;
            tick;
        end
        checks++;
        if (pin !== 1'b1 || dready !== 1'b1) begin
            errors++; $display("FAIL b2b_idle: pin=%b dready=%b expected 1/1", pin, dready);
        end
    endtask

    task automatic test_auto;
        logic [7:0] w;
        w = 8'h3C;
        tsmux = 2'b10;
        #1;
        checks++;
        if (dut.u_obuf.en_o !== 1'b0 || pin !== 1'b0) begin
            errors++; $display("FAIL auto_before: en=%b pin=%b expected 0/Z", dut.u_obuf.en_o, pin);
        end
        din = w; dvalid = 1'b1;
        tick;
        dvalid = 1'b0;
        checks++;
        if (dut.u_obuf.en_o !== 1'b0) begin
            errors++; $display("FAIL auto_accept: en=%b expected 0", dut.u_obuf.en_o);
        end
        tick;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.u_obuf.en_o !== 1'b1 || pin !== w[i]) begin
                errors++;
                $display("FAIL auto_bit%0d: en=%b pin=%b expected 1/%b", i, dut.u_obuf.en_o, pin, w[i]);
            end
            tick;
        end
        checks++;
        if (dut.u_obuf.en_o !== 1'b0 || pin !== 1'b0) begin
            errors++; $display("FAIL auto_after: en=%b pin=%b expected 0/Z", dut.u_obuf.en_o, pin);
        end
    endtask

    task automatic test_fabric_ts;
        logic [3:0] seq;
        seq = 4'b0101;
        tsmux = 2'b01; osel = 1'b0; out_b = 1'b1; ts = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            ts = seq[i];
            #1;
            checks++;
            if (dut.u_obuf.en_o !== (i == 0 ? 1'b0 : seq[i-1])) begin
                errors++; $display("FAIL ts_pre%0d: en=%b expected previous TS", i, dut.u_obuf.en_o);
            end
            tick;
            checks++;
            if (dut.u_obuf.en_o !== seq[i] || pin !== seq[i] || in_b !== seq[i]) begin
                errors++;
                $display("FAIL ts_post%0d: en=%b pin=%b in=%b expected %b", i, dut.u_obuf.en_o, pin, in_b, seq[i]);
            end
        end
        ts = 1'b0; osel = 1'b1; out_b = 1'b0; tsmux = 2'b11;
        tick;
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] w;
        w = 8'hF0;
        din = w; dvalid = 1'b1;
        tick;
        din = 8'h0F;
        tick;
        tick;
        dvalid = 1'b0;
        tick; tick;
        checks++;
        if (pin !== w[3] || dready !== 1'b0) begin
            errors++; $display("FAIL rst_bit3: pin=%b dready=%b expected %b/0", pin, dready, w[3]);
        end
        rstn = 1'b0;
        tick;
        checks++;
        if (pin !== 1'b1 || dready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL rst_hit: pin=%b dready=%b done=%b expected 1/1/0", pin, dready, done);
        end
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            checks++;
            if (pin !== 1'b1 || dready !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL rst_quiet%0d: pin=%b dready=%b done=%b expected 1/1/0", i, pin, dready, done);
            end
        end
        w = 8'h81;
        din = w; dvalid = 1'b1;
        tick;
        dvalid = 1'b0;
        tick;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pin !== w[i] || done !== (i == 7)) begin
                errors++;
                $display("FAIL rst_next_bit%0d: pin=%b done=%b expected %b/%b", i, pin, done, w[i], (i == 7));
            end
            tick;
        end
        checks++;
        if (pin !== 1'b1) begin
            errors++; $display("FAIL rst_next_idle: pin=%b expected 1", pin);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_auto;
        test_fabric_ts;
        test_reset_mid_word;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
